nexys_starship_game_timer: RTL

Parametrised BCD game timer for the Nexys Starship top level: counts elapsed play time up, or counts a preloaded time down, while the game is running. It is the successor to the fixed minutes:seconds counter that drives SSD4–SSD6. It adds a configurable tick rate and minute-digit count, count-down mode with expiry, a preload port, a saturate-or-wrap option and one-cycle event pulses. It runs on sys_clk and feeds the SSD mux and the game FSM (expiry → game over).

---
 rtl/nexys_starship_game_timer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/nexys_starship_game_timer.sv
// BCD mm:ss game timer: counts play time up, or a preloaded time down to expiry,
// one step per TICK_DIV clock cycles while Run is high.
module nexys_starship_game_timer #(
   parameter int TICK_DIV   = 100000000,
   parameter int MIN_DIGITS = 1,
   parameter bit WRAP       = 1'b0
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Run,
   input  logic                    Clear,
   input  logic                    Load,
   input  logic [4*MIN_DIGITS-1:0] Load_Min,
   input  logic [7:0]              Load_Sec,
   input  logic                    Mode,
   output logic [4*MIN_DIGITS-1:0] Min,
   output logic [3:0]              Sec_Tens,
   output logic [3:0]              Sec_Ones,
   output logic                    Sec_Tick,
   output logic                    Wrap_Pulse,
   output logic                    Max_Flag,
   output logic                    Expired,
   output logic                    Expire_Pulse
);

   localparam int              PW       = $clog2(TICK_DIV);
   localparam int              MW       = 4 * MIN_DIGITS;
   localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   function automatic logic [MW-1:0] clamp_min(input logic [MW-1:0] m);
      logic [MW-1:0] r;
      r = m;
      for (int i = 0; i < MIN_DIGITS; i++) r[4*i +: 4] = clamp_digit(m[4*i +: 4], 4'd9);
      return r;
   endfunction

   function automatic logic all_nine(input logic [MW-1:0] m);
      logic r;
      r = 1'b1;
      for (int i = 0; i < MIN_DIGITS; i++) r = r & (m[4*i +: 4] == 4'd9);
      return r;
   endfunction

   // Ripple carry across minute digits; all-nines rolls to zero.
   function automatic logic [MW-1:0] min_inc(input logic [MW-1:0] m);
      logic [MW-1:0] r;
      logic          c;
      r = m;
      c = 1'b1;
      for (int i = 0; i < MIN_DIGITS; i++) begin
         if (c) begin
            if (m[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = m[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [MW-1:0] min_dec(input logic [MW-1:0] m);
      logic [MW-1:0] r;
      logic          b;
      r = m;
      b = 1'b1;
      for (int i = 0; i < MIN_DIGITS; i++) begin
         if (b) begin
            if (m[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = m[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   logic [PW-1:0] presc_q, presc_d;
   logic [MW-1:0] min_q, min_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic          sec_tick_q, sec_tick_d;
   logic          wrap_pulse_q, wrap_pulse_d;
   logic          max_flag_q, max_flag_d;
   logic          expired_q, expired_d;
   logic          expire_pulse_q, expire_pulse_d;

   logic run_en, tick, at_max, at_zero;

   always_comb begin
      run_en  = Run & ~expired_q & ~max_flag_q;
      tick    = run_en & (presc_q == PRE_LAST);
      at_max  = all_nine(min_q) & (tens_q == 4'd5) & (ones_q == 4'd9);
      at_zero = (min_q == '0) & (tens_q == 4'd0) & (ones_q == 4'd0);

      presc_d        = presc_q;
      min_d          = min_q;
      tens_d         = tens_q;
      ones_d         = ones_q;
      sec_tick_d     = 1'b0;
      wrap_pulse_d   = 1'b0;
      max_flag_d     = max_flag_q;
      expired_d      = expired_q;
      expire_pulse_d = 1'b0;

      if (Clear) begin
         presc_d    = '0;
         min_d      = '0;
         tens_d     = 4'd0;
         ones_d     = 4'd0;
         max_flag_d = 1'b0;
         expired_d  = 1'b0;
      end else if (Load) begin
         presc_d    = '0;
         min_d      = clamp_min(Load_Min);
         tens_d     = clamp_digit(Load_Sec[7:4], 4'd5);
         ones_d     = clamp_digit(Load_Sec[3:0], 4'd9);
         max_flag_d = 1'b0;
         expired_d  = 1'b0;
      end else if (run_en) begin
         // A paused prescaler keeps its partial second; it only moves while enabled.
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick && !Mode) begin
            if (at_max) begin
               if (WRAP) begin
                  min_d        = '0;
                  tens_d       = 4'd0;
                  ones_d       = 4'd0;
                  wrap_pulse_d = 1'b1;
                  sec_tick_d   = 1'b1;
               end else begin
                  max_flag_d = 1'b1;
               end
            end else begin
               sec_tick_d = 1'b1;
               if (ones_q != 4'd9) begin
                  ones_d = ones_q + 4'd1;
               end else begin
                  ones_d = 4'd0;
                  if (tens_q != 4'd5) begin
                     tens_d = tens_q + 4'd1;
                  end else begin
                     tens_d = 4'd0;
                     min_d  = min_inc(min_q);
                  end
               end
            end
         end else if (tick && Mode) begin
            if (at_zero) begin
               expired_d      = 1'b1;
               expire_pulse_d = 1'b1;
            end else begin
               sec_tick_d = 1'b1;
               if (ones_q != 4'd0) begin
                  ones_d = ones_q - 4'd1;
               end else begin
                  ones_d = 4'd9;
                  if (tens_q != 4'd0) begin
                     tens_d = tens_q - 4'd1;
                  end else begin
                     tens_d = 4'd5;
                     min_d  = min_dec(min_q);
                  end
               end
               if ((min_d == '0) && (tens_d == 4'd0) && (ones_d == 4'd0)) begin
                  expired_d      = 1'b1;
                  expire_pulse_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         presc_q        <= '0;
         min_q          <= '0;
         tens_q         <= 4'd0;
         ones_q         <= 4'd0;
         sec_tick_q     <= 1'b0;
         wrap_pulse_q   <= 1'b0;
         max_flag_q     <= 1'b0;
         expired_q      <= 1'b0;
         expire_pulse_q <= 1'b0;
      end else begin
         presc_q        <= presc_d;
         min_q          <= min_d;
         tens_q         <= tens_d;
         ones_q         <= ones_d;
         sec_tick_q     <= sec_tick_d;
         wrap_pulse_q   <= wrap_pulse_d;
         max_flag_q     <= max_flag_d;
         expired_q      <= expired_d;
         expire_pulse_q <= expire_pulse_d;
      end
   end

   assign Min          = min_q;
   assign Sec_Tens     = tens_q;
   assign Sec_Ones     = ones_q;
   assign Sec_Tick     = sec_tick_q;
   assign Wrap_Pulse   = wrap_pulse_q;
   assign Max_Flag     = max_flag_q;
   assign Expired      = expired_q;
   assign Expire_Pulse = expire_pulse_q;

endmodule
